regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_slot.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: source encoding,
// holding-slot layout and the default register pointer width.
package regfile_wb_arbiter_pkg;

    localparam int PW_DEFAULT = 3;
    // Slot address field is sized for the widest supported pointer.
    localparam int SLOT_AW    = 8;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] addr;
        logic [7:0]         data;
        logic               scry;
        logic               ngtv;
        logic               zero;
    } slot_t;

endpackage

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry writeback holding slot: loads on accept, empties on grant,
// and is emptied by synchronous reset.
module wb_slot
    import regfile_wb_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  accept,
    input  logic  grant,
    input  slot_t load,
    output slot_t slot
);

    logic               valid_q;
    logic [SLOT_AW-1:0] addr_q;
    logic [7:0]         data_q;
    logic               scry_q;
    logic               ngtv_q;
    logic               zero_q;

    // NOTE: accept wins over grant so a drain and a refill in the same cycle keep the slot full.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= load.valid;
        end else if (grant) begin
            valid_q <= 1'b0;
        end
    end

    // NOTE: payload is deliberately not reset; valid_q alone decides whether it means anything.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= load.addr;
            data_q <= load.data;
            scry_q <= load.scry;
            ngtv_q <= load.ngtv;
            zero_q <= load.zero;
        end
    end

    always_comb begin
        slot.valid = valid_q;
        slot.addr  = addr_q;
        slot.data  = data_q;
        slot.scry  = scry_q;
        slot.ngtv  = ngtv_q;
        slot.zero  = zero_q;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between ALU and MEM writeback requests onto the
// register file's single write port, with per-register busy tracking.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int PW = PW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [PW-1:0]    alu_addr,
    input  logic [7:0]       alu_data,
    input  logic             alu_scry,
    input  logic             alu_ngtv,
    input  logic             alu_zero,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [PW-1:0]    mem_addr,
    input  logic [7:0]       mem_data,
    output logic             mem_ready,
    input  logic             cur_scry,
    input  logic             cur_ngtv,
    input  logic             cur_zero,
    output logic             wr_en,
    output logic [PW-1:0]    wr_addr,
    output logic [7:0]       wr_data,
    output logic             wr_scry,
    output logic             wr_ngtv,
    output logic             wr_zero,
    output logic             wr_src,
    output logic [2**PW-1:0] busy
);

    slot_t alu_load, mem_load, alu_s, mem_s, gnt_s;
    logic  alu_occ, mem_occ, gnt_alu, gnt_mem;
    src_e  last_q;

    always_comb begin
        alu_load = '{valid: alu_valid, addr: SLOT_AW'(alu_addr), data: alu_data,
                     scry: alu_scry, ngtv: alu_ngtv, zero: alu_zero};
        mem_load = '{valid: mem_valid, addr: SLOT_AW'(mem_addr), data: mem_data,
                     scry: 1'b0, ngtv: 1'b0, zero: 1'b0};
    end

    // Occupancy is masked by reset so nothing held is written or shown busy.
    assign alu_occ   = alu_s.valid && !reset;
    assign mem_occ   = mem_s.valid && !reset;
    assign gnt_alu   = alu_occ && (!mem_occ || last_q == SRC_MEM);
    assign gnt_mem   = mem_occ && !gnt_alu;
    assign alu_ready = !reset && (!alu_s.valid || gnt_alu);
    assign mem_ready = !reset && (!mem_s.valid || gnt_mem);

    wb_slot u_alu_slot (
        .clk    (clk),
        .reset  (reset),
        .accept (alu_valid && alu_ready),
        .grant  (gnt_alu),
        .load   (alu_load),
        .slot   (alu_s)
    );

    wb_slot u_mem_slot (
        .clk    (clk),
        .reset  (reset),
        .accept (mem_valid && mem_ready),
        .grant  (gnt_mem),
        .load   (mem_load),
        .slot   (mem_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= SRC_MEM;
        end else if (gnt_alu) begin
            last_q <= SRC_ALU;
        end else if (gnt_mem) begin
            last_q <= SRC_MEM;
        end
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        gnt_s   = gnt_mem ? mem_s : alu_s;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_scry = 1'b0;
        wr_ngtv = 1'b0;
        wr_zero = 1'b0;
        wr_src  = SRC_ALU;
        if (gnt_s.valid && !reset) begin
            wr_en   = 1'b1;
            wr_addr = PW'(gnt_s.addr);
            wr_data = gnt_s.data;
            wr_src  = gnt_mem ? SRC_MEM : SRC_ALU;
            // A load carries no flags, so the stored flags are written back unchanged.
            wr_scry = gnt_mem ? cur_scry : gnt_s.scry;
            wr_ngtv = gnt_mem ? cur_ngtv : gnt_s.ngtv;
            wr_zero = gnt_mem ? cur_zero : gnt_s.zero;
        end
    end

    always_comb begin
        busy = '0;
        for (int k = 0; k < 2**PW; k++) begin
            busy[k] = (alu_occ && alu_s.addr == SLOT_AW'(k)) ||
                      (mem_occ && mem_s.addr == SLOT_AW'(k));
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a scoreboard queue holds the writes
// expected on the write port in grant order; a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;

    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, alu_scry, alu_ngtv, alu_zero, alu_ready;
    logic [PW-1:0] alu_addr;
    logic [7:0]    alu_data;
    logic          mem_valid, mem_ready;
    logic [PW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          cur_scry, cur_ngtv, cur_zero;
    logic          wr_en, wr_scry, wr_ngtv, wr_zero, wr_src;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    busy;

    int            total = 0;
    int            bad   = 0;
    logic [31:0]   exp_q[$];
    logic [7:0]    rf[8];

    regfile_wb_arbiter #(.PW(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_scry  (alu_scry),
        .alu_ngtv  (alu_ngtv),
        .alu_zero  (alu_zero),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .cur_scry  (cur_scry),
        .cur_ngtv  (cur_ngtv),
        .cur_zero  (cur_zero),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_scry   (wr_scry),
        .wr_ngtv   (wr_ngtv),
        .wr_zero   (wr_zero),
        .wr_src    (wr_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic src, input logic s, input logic n,
                                       input logic z, input logic [PW-1:0] a,
                                       input logic [7:0] d);
        return 32'({src, s, n, z, a, d});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [PW-1:0] a, input logic [7:0] d,
                             input logic s, input logic n, input logic z);
        alu_valid = v; alu_addr = a; alu_data = d;
        alu_scry = s; alu_ngtv = n; alu_zero = z;
    endtask

    task automatic drive_mem(input logic v, input logic [PW-1:0] a, input logic [7:0] d);
        mem_valid = v; mem_addr = a; mem_data = d;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Register-file model: captures whatever the arbiter writes.
    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

    // Scoreboard monitor: every write-port pulse must match the next expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", pk(wr_src, wr_scry, wr_ngtv, wr_zero, wr_addr, wr_data), 32'hFFFF_FFFF);
            end else begin
                check("wr_port", pk(wr_src, wr_scry, wr_ngtv, wr_zero, wr_addr, wr_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ar_exp[7] = '{1, 1, 0, 1, 0, 1, 1};
        bit mr_exp[7] = '{1, 0, 1, 0, 1, 0, 1};
        int ai, mi;
        logic ar, mr;

        reset = 1'b1;
        drive_alu(0, 0, 0, 0, 0, 0);
        drive_mem(0, 0, 0);
        cur_scry = 0; cur_ngtv = 0; cur_zero = 0;
        step(); step();

        // Reset state
        @(negedge clk);
        check("rst_alu_ready", 32'(alu_ready), 0);
        check("rst_mem_ready", 32'(mem_ready), 0);
        check("rst_busy", 32'(busy), 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_wr_en", 32'(wr_en), 0);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_alu_ready", 32'(alu_ready), 1);
        check("post_rst_mem_ready", 32'(mem_ready), 1);

        // Uncontested ALU write
        step();
        drive_alu(1, 3, 8'h5A, 1, 0, 0);
        exp_q.push_back(pk(0, 1, 0, 0, 3, 8'h5A));
        @(negedge clk);
        check("alu_ready_idle", 32'(alu_ready), 1);
        step();
        alu_valid = 0;
        @(negedge clk);
        check("alu_wr_en", 32'(wr_en), 1);
        check("alu_busy", 32'(busy), 32'h08);
        step();
        @(negedge clk);
        check("idle_wr_en", 32'(wr_en), 0);
        check("idle_wr_fields", pk(wr_src, wr_scry, wr_ngtv, wr_zero, wr_addr, wr_data), 0);
        check("idle_busy", 32'(busy), 0);

        // Both requesters in the same cycle right after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        cur_scry = 0; cur_ngtv = 1; cur_zero = 1;
        drive_alu(1, 1, 8'h11, 0, 0, 1);
        drive_mem(1, 2, 8'h22);
        exp_q.push_back(pk(0, 0, 0, 1, 1, 8'h11));
        exp_q.push_back(pk(1, 0, 1, 1, 2, 8'h22));
        step();
        alu_valid = 0;
        mem_valid = 0;
        @(negedge clk);
        check("both_c1_mem_ready", 32'(mem_ready), 0);
        check("both_c1_alu_ready", 32'(alu_ready), 1);
        check("both_c1_busy", 32'(busy), 32'h06);
        step();
        @(negedge clk);
        check("both_c2_mem_ready", 32'(mem_ready), 1);
        drain("drain_both");

        // Continuous contention: three ALU and three MEM requests, alternating grants
        cur_scry = 1; cur_ngtv = 0; cur_zero = 1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pk(0, i[0], 1, 0, PW'(i), 8'hA0 + 8'(i)));
            exp_q.push_back(pk(1, 1, 0, 1, PW'(4 + i), 8'hB0 + 8'(i)));
        end
        ai = 0;
        mi = 0;
        drive_alu(1, 0, 8'hA0, 0, 1, 0);
        drive_mem(1, 4, 8'hB0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ar = alu_ready;
            mr = mem_ready;
            check($sformatf("rr_alu_ready_c%0d", c), 32'(ar), 32'(ar_exp[c]));
            check($sformatf("rr_mem_ready_c%0d", c), 32'(mr), 32'(mr_exp[c]));
            step();
            if (alu_valid && ar) begin
                ai++;
                if (ai < 3) drive_alu(1, PW'(ai), 8'hA0 + 8'(ai), ai[0], 1, 0);
                else alu_valid = 0;
            end
            if (mem_valid && mr) begin
                mi++;
                if (mi < 3) drive_mem(1, PW'(4 + mi), 8'hB0 + 8'(mi));
                else mem_valid = 0;
            end
        end
        drain("drain_rr");

        // Same-address conflict with the pointer at MEM
        cur_scry = 0; cur_ngtv = 0; cur_zero = 0;
        drive_alu(1, 5, 8'hAA, 0, 1, 1);
        drive_mem(1, 5, 8'hBB);
        exp_q.push_back(pk(0, 0, 1, 1, 5, 8'hAA));
        exp_q.push_back(pk(1, 0, 0, 0, 5, 8'hBB));
        step();
        alu_valid = 0;
        mem_valid = 0;
        @(negedge clk);
        check("same_addr_busy", 32'(busy), 32'h20);
        step();
        step();
        @(negedge clk);
        check("same_addr_rf5", 32'(rf[5]), 32'hBB);
        drain("drain_same");

        // Reset with both slots full
        drive_alu(1, 6, 8'h66, 1, 1, 1);
        drive_mem(1, 7, 8'h77);
        step();
        reset = 1'b1;
        alu_valid = 0;
        mem_valid = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_full_wr_en", 32'(wr_en), 0);
            check("rst_full_busy", 32'(busy), 0);
            check("rst_full_readys", 32'({alu_ready, mem_ready}), 0);
            step();
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_full_after_readys", 32'({alu_ready, mem_ready}), 32'h3);
        check("rst_full_after_wr_en", 32'(wr_en), 0);
        check("rst_full_after_busy", 32'(busy), 0);

        // Streaming ALU writes to addresses 0..7
        for (int i = 0; i < 8; i++) begin
            step();
            drive_alu(1, PW'(i), 8'h30 + 8'(i), i[0], i[1], i[2]);
            exp_q.push_back(pk(0, i[0], i[1], i[2], PW'(i), 8'h30 + 8'(i)));
            @(negedge clk);
            check($sformatf("stream_ready_%0d", i), 32'(alu_ready), 1);
            if (i > 0) check($sformatf("stream_wr_en_%0d", i), 32'(wr_en), 1);
        end
        step();
        alu_valid = 0;
        @(negedge clk);
        check("stream_wr_en_last", 32'(wr_en), 1);
        step();
        @(negedge clk);
        check("stream_done_wr_en", 32'(wr_en), 0);
        drain("drain_stream");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
